// File: rtl/pad_output_scheduler_pkg.sv
// Shared types and constants for the pad output scheduler.
// Frame = header word {sync, source id} followed by one payload word.
package pad_output_scheduler_pkg;

  localparam int DATA_W = 16;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] make_header(input logic [7:0] sync,
                                                    input logic [7:0] id);
    return {sync, id};
  endfunction

endpackage

// File: rtl/pad_output_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after last_grant.
// Returns a one-hot grant, its index and whether any grant was made.
module pad_output_scheduler_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_SRC-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  int               idx_int;
  logic [IDX_W-1:0] idx_sel;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx_int     = 0;
    idx_sel     = '0;
    // Scan starting one past the previous winner so it ends with lowest priority.
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx_int = (int'(last_grant) + k) % NUM_SRC;
      idx_sel = IDX_W'(idx_int);
      if (!grant_valid && req[idx_sel]) begin
        grant_valid    = 1'b1;
        grant_idx      = idx_sel;
        grant[idx_sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pad_output_scheduler.sv
// Time-shares the 16-bit pad bus between NUM_SRC sources, one HEADER+DATA
// frame per grant, each word held HOLD_CYCLES clocks.
//
// state   | meaning
// IDLE    | pads at 0, waiting for en and a request
// HDR     | header {SYNC_BYTE, id} on pads for HOLD_CYCLES
// DATA    | captured payload on pads; last cycle may accept the next frame
module pad_output_scheduler
  import pad_output_scheduler_pkg::*;
#(
  parameter int         NUM_SRC     = 4,
  parameter int         HOLD_CYCLES = 2,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [NUM_SRC-1:0]        req_valid,
  input  logic [NUM_SRC*DATA_W-1:0] req_data,
  output logic [NUM_SRC-1:0]        req_ready,
  output logic [DATA_W-1:0]         pad_data,
  output logic                      pad_strobe,
  output logic                      pad_frame,
  output logic [15:0]               frames_sent
);

  localparam int IDX_W  = $clog2(NUM_SRC);
  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [IDX_W-1:0]    last_grant;
  logic [DATA_W-1:0]   cap_data;

  logic [NUM_SRC-1:0]  grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_valid;
  logic [DATA_W-1:0]   sel_data;
  logic                hold_last;
  logic                can_grant;
  logic                accept;

  pad_output_scheduler_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req         (req_valid),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign hold_last = (hold_cnt == HOLD_ONE);
  // Grants only from IDLE or the final DATA cycle, which gives gapless back-to-back frames.
  assign can_grant = en && !reset &&
                     ((state == ST_IDLE) || ((state == ST_DATA) && hold_last));
  assign accept    = can_grant && grant_valid;
  assign req_ready = accept ? grant : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      last_grant  <= IDX_W'(NUM_SRC - 1);
      cap_data    <= '0;
      pad_data    <= '0;
      pad_strobe  <= 1'b0;
      pad_frame   <= 1'b0;
      frames_sent <= '0;
    end else begin
      pad_strobe <= 1'b0;
      if ((state == ST_DATA) && hold_last) frames_sent <= frames_sent + 16'd1;

      if (accept) begin
        state      <= ST_HDR;
        hold_cnt   <= HOLD_LOAD;
        last_grant <= grant_idx;
        cap_data   <= sel_data;
        pad_data   <= make_header(SYNC_BYTE, 8'(grant_idx));
        pad_strobe <= 1'b1;
        pad_frame  <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            pad_data  <= '0;
            pad_frame <= 1'b0;
          end
          ST_HDR: begin
            if (hold_last) begin
              state      <= ST_DATA;
              hold_cnt   <= HOLD_LOAD;
              pad_data   <= cap_data;
              pad_strobe <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt - HOLD_ONE;
            end
          end
          ST_DATA: begin
            if (hold_last) begin
              state     <= ST_IDLE;
              hold_cnt  <= '0;
              pad_data  <= '0;
              pad_frame <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt - HOLD_ONE;
            end
          end
          default: begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            pad_data  <= '0;
            pad_frame <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pad_output_scheduler.sv
// Directed bench for pad_output_scheduler (NUM_SRC=4, HOLD_CYCLES=2).
// Each step drives inputs right after a rising edge and checks after settling.
module tb_pad_output_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic [15:0] pad_data;
  logic        pad_strobe;
  logic        pad_frame;
  logic [15:0] frames_sent;

  int n_cmp = 0;
  int n_err = 0;

  pad_output_scheduler #(
    .NUM_SRC     (4),
    .HOLD_CYCLES (2),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .pad_data    (pad_data),
    .pad_strobe  (pad_strobe),
    .pad_frame   (pad_frame),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp_ready;

  initial begin
    reset     = 1'b1;
    en        = 1'b0;
    req_valid = 4'b0000;
    req_data  = '0;
    tick();
    tick();
    check("rst_pad_data", 32'(pad_data), 32'h0);
    check("rst_pad_frame", 32'(pad_frame), 32'h0);
    check("rst_pad_strobe", 32'(pad_strobe), 32'h0);
    check("rst_frames_sent", 32'(frames_sent), 32'h0);
    reset = 1'b0;
    tick();

    // Single frame from src1
    en        = 1'b1;
    req_data  = {16'h0000, 16'h0000, 16'h1234, 16'h0000};
    req_valid = 4'b0010;
    #1;
    check("t1_ready_T", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    check("t1_hdr_T1", 32'(pad_data), 32'hA501);
    check("t1_strobe_T1", 32'(pad_strobe), 32'h1);
    check("t1_frame_T1", 32'(pad_frame), 32'h1);
    #1;
    check("t1_ready_hdr", 32'(req_ready), 32'h0);
    tick();
    check("t1_hdr_T2", 32'(pad_data), 32'hA501);
    check("t1_strobe_T2", 32'(pad_strobe), 32'h0);
    tick();
    check("t1_data_T3", 32'(pad_data), 32'h1234);
    check("t1_strobe_T3", 32'(pad_strobe), 32'h1);
    tick();
    check("t1_data_T4", 32'(pad_data), 32'h1234);
    check("t1_strobe_T4", 32'(pad_strobe), 32'h0);
    check("t1_frame_T4", 32'(pad_frame), 32'h1);
    tick();
    check("t1_idle_pad", 32'(pad_data), 32'h0);
    check("t1_idle_frame", 32'(pad_frame), 32'h0);
    check("t1_count", 32'(frames_sent), 32'h1);

    // All sources requesting from a fresh reset: order 0,1,2,3,0 back-to-back
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
    req_data  = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_ready = 4'b0001 << (k % 4);
      check("t2_ready", 32'(req_ready), 32'(exp_ready));
      tick();
      if (k == 4) req_valid = 4'b0000;
      check("t2_hdr", 32'(pad_data), 32'hA500 + 32'(k % 4));
      check("t2_frame_h1", 32'(pad_frame), 32'h1);
      tick();
      check("t2_frame_h2", 32'(pad_frame), 32'h1);
      tick();
      check("t2_data", 32'(pad_data), 32'hD000 + 32'(k % 4));
      tick();
      check("t2_frame_d2", 32'(pad_frame), 32'h1);
    end
    tick();
    check("t2_idle_frame", 32'(pad_frame), 32'h0);
    check("t2_count", 32'(frames_sent), 32'h5);

    // en low holds off src2 until raised
    en        = 1'b0;
    req_data  = {16'h0000, 16'h2222, 16'h0000, 16'h0000};
    req_valid = 4'b0100;
    #1;
    check("t3_ready_en0", 32'(req_ready), 32'h0);
    tick();
    check("t3_pad_en0", 32'(pad_data), 32'h0);
    tick();
    check("t3_frame_en0", 32'(pad_frame), 32'h0);
    en = 1'b1;
    #1;
    check("t3_ready_en1", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    check("t3_hdr", 32'(pad_data), 32'hA502);
    tick();
    tick();
    check("t3_data", 32'(pad_data), 32'h2222);
    tick();
    tick();
    check("t3_count", 32'(frames_sent), 32'h6);

    // en drops during HDR: frame completes, nothing new granted
    req_data  = {16'hBEEF, 16'h0000, 16'h0000, 16'h0000};
    req_valid = 4'b1000;
    #1;
    check("t4_ready", 32'(req_ready), 32'h8);
    tick();
    en        = 1'b0;
    req_valid = 4'b0001;
    check("t4_hdr", 32'(pad_data), 32'hA503);
    tick();
    tick();
    check("t4_data", 32'(pad_data), 32'hBEEF);
    tick();
    check("t4_ready_last", 32'(req_ready), 32'h0);
    tick();
    check("t4_idle_frame", 32'(pad_frame), 32'h0);
    check("t4_count", 32'(frames_sent), 32'h7);
    tick();
    check("t4_still_idle", 32'(pad_frame), 32'h0);

    // Reset during DATA abandons the frame and restores src0 priority
    en        = 1'b1;
    req_data  = {16'h0000, 16'h0000, 16'h0000, 16'h5555};
    req_valid = 4'b0001;
    #1;
    check("t5_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    check("t5_data", 32'(pad_data), 32'h5555);
    reset = 1'b1;
    #2;
    check("t5_rst_pad", 32'(pad_data), 32'h0);
    check("t5_rst_frame", 32'(pad_frame), 32'h0);
    check("t5_rst_count", 32'(frames_sent), 32'h0);
    reset = 1'b0;
    req_data  = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
    req_valid = 4'b1111;
    #1;
    check("t5_ready_src0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    check("t5_hdr", 32'(pad_data), 32'hA500);
    tick();
    tick();
    tick();
    tick();
    check("t5_count", 32'(frames_sent), 32'h1);

    // Counter wrap: start from 16'hFFFF instead of streaming 65535 frames
    force dut.frames_sent = 16'hFFFF;
    #1;
    release dut.frames_sent;
    req_data  = {16'h0000, 16'h0000, 16'h7777, 16'h0000};
    req_valid = 4'b0010;
    #1;
    check("t6_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    tick();
    check("t6_pre_wrap", 32'(frames_sent), 32'hFFFF);
    tick();
    check("t6_wrap", 32'(frames_sent), 32'h0);
    check("t6_idle_frame", 32'(pad_frame), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
